serial_collector: RTL and testbench
===================================

SERIAL_COLLECTOR -- requirements
Module: serial_collector

Interface
REQ-001 Parameter: WIDTH, default 4, number of bits per serial frame (legal range 2..32).
REQ-002 Port: CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: RST  input  1  reset, synchronous, active-high.
REQ-004 Port: Start  input  1  frame-start strobe; the In value on the Start cycle is frame bit 0.
REQ-005 Port: In  input  1  serial data bit, LSB first, one bit per clock during a frame.
REQ-006 Port: Ready  input  1  consumer accepts Data when high while Valid is high.
REQ-007 Port: Data  output  WIDTH  assembled parallel word, registered.
REQ-008 Port: Valid  output  1  Data holds a complete, unconsumed frame.
REQ-009 Port: Busy  output  1  a frame is being shifted in.
REQ-010 Port: Overrun  output  1  sticky flag: a frame start was refused because Data was unconsumed.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and HOLD; encoding is free.
REQ-012 IDLE with Start=1 SHALL capture In as bit 0, load bit count 1, and go to SHIFT; Ready is ignored in IDLE.
REQ-013 The internal shift register SHALL shift right with In entering at the MSB (next = {In, sr[WIDTH-1:1]}), so bit 0 ends at Data[0].
REQ-014 SHIFT SHALL sample In every cycle; after the WIDTH-th bit is sampled it SHALL go to HOLD.
REQ-015 Latency: Start at edge k (bit 0) -> last bit at edge k+WIDTH-1 -> Data and Valid updated at that same edge, so both are visible in cycle k+WIDTH.
REQ-016 Data SHALL change only on frame completion; partial frames are never visible on Data.
REQ-017 Busy SHALL be 1 exactly while in SHIFT, and 0 in IDLE and HOLD.
REQ-018 Start during SHIFT SHALL be ignored: no restart, no count change, no Overrun.
REQ-019 HOLD: Valid=1 and Data held stable until a rising edge with Ready=1.
REQ-020 HOLD with Ready=1 and Start=0 SHALL clear Valid and go to IDLE.
REQ-021 HOLD with Ready=1 and Start=1 (back-to-back) SHALL clear Valid, capture In as bit 0 of the new frame, and go to SHIFT; no idle cycle and no Overrun.
REQ-022 HOLD with Ready=0 and Start=1 SHALL set Overrun, ignore the Start, and keep Data and Valid unchanged.
REQ-023 Overrun SHALL be cleared only by RST.
REQ-024 The bit counter SHALL be wide enough for WIDTH and SHALL not wrap within a frame.

Reset
REQ-025 RST=1 at a rising edge SHALL force: state IDLE, Data=0, Valid=0, Busy=0, Overrun=0, bit count 0, shift register 0.
REQ-026 RST SHALL take priority over Start and Ready in the same cycle.
REQ-027 RST during SHIFT or HOLD SHALL discard the partial or held frame; Valid SHALL not assert for it.
REQ-028 After RST deasserts, a Start in the first cycle SHALL be accepted normally.

Verification (WIDTH=4)
REQ-029 Basic frame: Start with In=1,0,1,1 on consecutive cycles (bit0 first), Ready=0 -> in cycle 4, Data=4'hD and Valid=1; Busy=1 in cycles 1..3 only.
REQ-030 Hold and consume: continue REQ-029 and hold Ready=0 for 5 cycles -> Data stays 4'hD and Valid stays 1; Ready=1 for one cycle -> Valid=0 next cycle and state is IDLE.
REQ-031 Back-to-back: in HOLD with Data=4'hD, drive Ready=1 and Start=1 with In=0 and then 1,1,0 -> Valid drops for 3 cycles, then Data=4'h6 and Valid=1; Overrun=0.
REQ-032 Overrun: in HOLD with Ready=0, pulse Start -> Overrun=1, Data unchanged, Busy=0; Overrun stays 1 after a later consume, until RST.
REQ-033 Start during SHIFT: pulse Start again at bit 2 of frame 1,1,1,1 -> frame completes on schedule with Data=4'hF.
REQ-034 Reset mid-frame: assert RST after 2 bits -> next cycle Busy=0, Valid=0, Data=0; a fresh frame 0,1,0,0 then yields Data=4'h2.

Source files
------------

// File: rtl/serial_collector.sv
// serial_collector: assembles LSB-first serial frames into a parallel word with a valid/ready handshake
module serial_collector #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             In,
  input  logic             Ready,
  output logic [WIDTH-1:0] Data,
  output logic             Valid,
  output logic             Busy,
  output logic             Overrun
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] sr, sr_shift;
  logic [CW-1:0] cnt;
  logic last, take;
  assign sr_shift = {In, sr[WIDTH-1:1]};
  assign last = cnt == CW'(WIDTH - 1);
  assign take = Start && (state == IDLE || (state == HOLD && Ready));
  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= state_next;
  end
  // next state: a held word blocks new frames until it is consumed
  always_comb begin
    state_next = state == IDLE  ? (Start ? SHIFT : IDLE) :
                 state == SHIFT ? (last ? HOLD : SHIFT) :
                 (Ready ? (Start ? SHIFT : IDLE) : HOLD);
  end
  // state-decoded status outputs
  always_comb begin
    Busy = state == SHIFT;
    Valid = state == HOLD;
  end
  // datapath: shift register, bit count, output word and sticky overrun
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr <= '0;
      cnt <= '0;
      Data <= '0;
      Overrun <= 1'b0;
    end else begin
      if (take || state == SHIFT) sr <= sr_shift;
      if (take) cnt <= CW'(1);
      else if (state == SHIFT) cnt <= last ? '0 : cnt + CW'(1);
      if (state == SHIFT && last) Data <= sr_shift;
      if (state == HOLD && !Ready && Start) Overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_collector.sv
// tb_serial_collector: directed frames with a scoreboard of expected words checked by a monitor
module tb_serial_collector;
  logic CLK = 0, RST = 1, Start = 0, In = 0, Ready = 0;
  logic [3:0] Data;
  logic Valid, Busy, Overrun;
  logic [3:0] exp_q[$];
  logic [3:0] last_data = '0;
  logic pv = 0;
  int errors = 0, checks = 0;

  serial_collector #(.WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .In(In), .Ready(Ready),
    .Data(Data), .Valid(Valid), .Busy(Busy), .Overrun(Overrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic status(input string name, input logic v, input logic b, input logic o);
    check({name, " valid"}, 32'(Valid), 32'(v));
    check({name, " busy"}, 32'(Busy), 32'(b));
    check({name, " overrun"}, 32'(Overrun), 32'(o));
  endtask

  // sends bits LSB first starting with a Start strobe; expected word goes to the scoreboard
  task automatic frame(input logic [3:0] bits, input logic [3:0] exp, input string name);
    exp_q.push_back(exp);
    for (int i = 0; i < 4; i++) begin
      Start = (i == 0);
      In = bits[i];
      tick();
      if (i < 3) status({name, " shifting"}, 1'b0, 1'b1, Overrun);
    end
    Start = 0;
    check({name, " data"}, 32'(Data), 32'(exp));
  endtask

  // monitor: each newly presented word must match the scoreboard head and stay stable while held
  always @(negedge CLK) begin
    if (!RST) begin
      if (Valid && !pv) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_valid: got data %0h expected no word", Data);
        end else check("scoreboard word", 32'(Data), 32'(exp_q.pop_front()));
      end else if (Valid && pv) check("held data stable", 32'(Data), 32'(last_data));
    end
    pv = Valid;
    last_data = Data;
  end

  initial begin
    tick();
    tick();
    check("reset data", 32'(Data), 0);
    status("reset", 0, 0, 0);
    RST = 0;
    Ready = 0;
    frame(4'b1101, 4'hD, "basic");
    status("basic done", 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold data", 32'(Data), 32'hD);
      check("hold valid", 32'(Valid), 1);
    end
    Ready = 1;
    tick();
    Ready = 0;
    status("consumed", 0, 0, 0);
    frame(4'b1101, 4'hD, "again");
    exp_q.push_back(4'h6);
    Ready = 1;
    Start = 1;
    In = 0;
    tick();
    Ready = 0;
    Start = 0;
    status("b2b bit0", 0, 1, 0);
    In = 1;
    tick();
    status("b2b bit1", 0, 1, 0);
    tick();
    status("b2b bit2", 0, 1, 0);
    In = 0;
    tick();
    status("b2b done", 1, 0, 0);
    check("b2b data", 32'(Data), 32'h6);
    Start = 1;
    In = 1;
    tick();
    Start = 0;
    status("overrun", 1, 0, 1);
    check("overrun data", 32'(Data), 32'h6);
    tick();
    Ready = 1;
    tick();
    Ready = 0;
    status("overrun sticky", 0, 0, 1);
    tick();
    exp_q.push_back(4'hF);
    Start = 1;
    In = 1;
    tick();
    Start = 0;
    tick();
    Start = 1;
    tick();
    Start = 0;
    status("start in shift", 0, 1, 1);
    tick();
    status("start in shift done", 1, 0, 1);
    check("start in shift data", 32'(Data), 32'hF);
    Ready = 1;
    tick();
    Ready = 0;
    Start = 1;
    In = 1;
    tick();
    Start = 0;
    tick();
    RST = 1;
    Start = 1;
    tick();
    status("mid reset", 0, 0, 0);
    check("mid reset data", 32'(Data), 0);
    RST = 0;
    frame(4'b0010, 4'h2, "after reset");
    status("after reset done", 1, 0, 0);
    Ready = 1;
    tick();
    Ready = 0;
    tick();
    check("scoreboard drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
